// File: rtl/state_step_if.sv
// Bundle between the state-step controller and its environment: unit reports,
// step control inputs and the step pulse/status outputs.
interface state_step_if #(
  parameter int N_UNITS   = 4,
  parameter int STATE_W   = 4,
  parameter int TIMEOUT_W = 8
);
  logic [STATE_W-1:0]   state;
  logic [N_UNITS-1:0]   unit_mask;
  logic [N_UNITS-1:0]   unit_done;
  logic                 hold;
  logic [TIMEOUT_W-1:0] timeout_limit;
  logic                 err_clr;
  logic                 next_state;
  logic [N_UNITS-1:0]   done_pending;
  logic                 timeout_err;
  logic                 sync_err;
  logic [15:0]          step_cnt;

  modport master (
    output state, unit_mask, unit_done, hold, timeout_limit, err_clr,
    input  next_state, done_pending, timeout_err, sync_err, step_cnt
  );

  modport slave (
    input  state, unit_mask, unit_done, hold, timeout_limit, err_clr,
    output next_state, done_pending, timeout_err, sync_err, step_cnt
  );
endinterface

// File: rtl/state_step_controller.sv
// Producer side of the global state-step handshake: gathers unit done reports
// and issues one registered next_state pulse per pipeline state.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARM      | latch mask/state, clear timer (1 cycle)
// COLLECT  | retire done bits, honour hold, watch timeout
// PULSE    | next_state high for exactly this cycle
// WAIT_CHG | wait for state bus to move; flag sync_err after SYNC_WAIT
module state_step_controller #(
  parameter int N_UNITS   = 4,
  parameter int STATE_W   = 4,
  parameter int TIMEOUT_W = 8,
  parameter int SYNC_WAIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  state_step_if.slave  bus
);
  localparam logic [1:0] ARM      = 2'd0;
  localparam logic [1:0] COLLECT  = 2'd1;
  localparam logic [1:0] PULSE    = 2'd2;
  localparam logic [1:0] WAIT_CHG = 2'd3;
  localparam int SW_W = $clog2(SYNC_WAIT + 1);

  logic [1:0]           fsm_q, fsm_d;
  logic [N_UNITS-1:0]   pend_q, pend_d;
  logic [STATE_W-1:0]   cap_q, cap_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [SW_W-1:0]      wait_q, wait_d;
  logic                 ns_q, ns_d;
  logic                 terr_q, terr_d;
  logic                 serr_q, serr_d;
  logic [15:0]          step_q, step_d;
  logic                 terr_set, serr_set, timeout_hit;

  assign timeout_hit = (bus.timeout_limit != '0) && (timer_q == bus.timeout_limit) &&
                       (pend_q != '0);

  always_comb begin
    fsm_d    = fsm_q;
    pend_d   = pend_q;
    cap_d    = cap_q;
    timer_d  = timer_q;
    wait_d   = wait_q;
    step_d   = step_q;
    terr_set = 1'b0;
    serr_set = 1'b0;
    case (fsm_q)
      ARM: begin
        pend_d  = bus.unit_mask & ~bus.unit_done;
        cap_d   = bus.state;
        timer_d = '0;
        fsm_d   = COLLECT;
      end
      COLLECT: begin
        if (timeout_hit) begin
          terr_set = 1'b1;
          pend_d   = '0;
          fsm_d    = PULSE;
        end else if (pend_q == '0) begin
          // timer stays frozen while held with nothing pending
          if (!bus.hold) fsm_d = PULSE;
        end else begin
          pend_d = pend_q & ~bus.unit_done;
          if (timer_q != '1) timer_d = timer_q + 1'b1;
        end
      end
      PULSE: begin
        step_d = step_q + 16'd1;
        pend_d = '0;
        wait_d = '0;
        fsm_d  = WAIT_CHG;
      end
      WAIT_CHG: begin
        // unit_done here still refers to the old state and is dropped
        if (bus.state != cap_q) begin
          fsm_d = ARM;
        end else if (wait_q == SW_W'(SYNC_WAIT - 1)) begin
          serr_set = 1'b1;
          fsm_d    = ARM;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: fsm_d = ARM;
    endcase
    ns_d   = (fsm_d == PULSE);
    terr_d = terr_set ? 1'b1 : (bus.err_clr ? 1'b0 : terr_q);
    serr_d = serr_set ? 1'b1 : (bus.err_clr ? 1'b0 : serr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ARM;
      pend_q  <= '0;
      cap_q   <= '0;
      timer_q <= '0;
      wait_q  <= '0;
      ns_q    <= 1'b0;
      terr_q  <= 1'b0;
      serr_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      pend_q  <= pend_d;
      cap_q   <= cap_d;
      timer_q <= timer_d;
      wait_q  <= wait_d;
      ns_q    <= ns_d;
      terr_q  <= terr_d;
      serr_q  <= serr_d;
      step_q  <= step_d;
    end
  end

  assign bus.next_state   = ns_q;
  assign bus.done_pending = pend_q;
  assign bus.timeout_err  = terr_q;
  assign bus.sync_err     = serr_q;
  assign bus.step_cnt     = step_q;
endmodule

// File: tb/tb_state_step_controller.sv
// Directed bench for state_step_controller with a negedge-sampling state
// counter model driven by next_state.
module tb_state_step_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt_rst = 1'b1;
  logic [3:0] st = 4'd0;
  int         total = 0;
  int         bad = 0;
  int         n;
  logic       seen;

  state_step_if sif ();
  assign sif.state = st;

  state_step_controller dut (.clk(clk), .rst(rst), .bus(sif));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_rst)             st <= 4'd0;
    else if (sif.next_state) st <= st + 4'd1;
  end

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  done;
    logic        hold;
    logic [3:0]  exp_dp;
    logic        exp_ns;
    logic [15:0] exp_step;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cnt_rst = 1'b1;
    sif.unit_mask = '0;
    sif.unit_done = '0;
    sif.hold = 1'b0;
    sif.timeout_limit = '0;
    sif.err_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    cnt_rst = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output int cnt);
    cnt = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (sif.next_state) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    tbl[0] = '{4'b0011, 4'b0000, 1'b0, 4'b0011, 1'b0, 16'd0};
    tbl[1] = '{4'b0011, 4'b0000, 1'b0, 4'b0011, 1'b0, 16'd0};
    tbl[2] = '{4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 16'd0};
    tbl[3] = '{4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0, 16'd0};
    tbl[4] = '{4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0, 16'd0};
    tbl[5] = '{4'b0011, 4'b0010, 1'b0, 4'b0000, 1'b0, 16'd0};
    tbl[6] = '{4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'd0};
    tbl[7] = '{4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd1};
    tbl[8] = '{4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd1};
    tbl[9] = '{4'b0011, 4'b0000, 1'b0, 4'b0011, 1'b0, 16'd1};

    // reset values
    do_reset();
    chk("rst_ns", 32'(sif.next_state), 0);
    chk("rst_dp", 32'(sif.done_pending), 0);
    chk("rst_terr", 32'(sif.timeout_err), 0);
    chk("rst_serr", 32'(sif.sync_err), 0);
    chk("rst_step", 32'(sif.step_cnt), 0);

    // two-unit collect, one step
    for (int i = 0; i < 10; i++) begin
      sif.unit_mask = tbl[i].mask;
      sif.unit_done = tbl[i].done;
      sif.hold      = tbl[i].hold;
      tick();
      chk($sformatf("t1_dp[%0d]", i), 32'(sif.done_pending), 32'(tbl[i].exp_dp));
      chk($sformatf("t1_ns[%0d]", i), 32'(sif.next_state), 32'(tbl[i].exp_ns));
      chk($sformatf("t1_step[%0d]", i), 32'(sif.step_cnt), 32'(tbl[i].exp_step));
    end
    chk("t1_state", 32'(st), 1);

    // empty mask: 16 steps, 4-cycle period, state wraps
    do_reset();
    for (int k = 0; k < 16; k++) begin
      wait_pulse(10, n);
      chk($sformatf("t2_gap[%0d]", k), n, (k == 0) ? 2 : 4);
    end
    tick();
    chk("t2_step", 32'(sif.step_cnt), 16);
    chk("t2_state", 32'(st), 0);
    repeat (4) tick();
    chk("t2_serr", 32'(sif.sync_err), 0);

    // hold blocks the step, release steps on the next edge
    do_reset();
    sif.unit_mask = 4'b0001;
    sif.unit_done = 4'b0001;
    sif.hold = 1'b1;
    tick();
    sif.unit_done = 4'b0000;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (sif.next_state) seen = 1'b1;
    end
    chk("t3_hold_nopulse", 32'(seen), 0);
    chk("t3_hold_dp", 32'(sif.done_pending), 0);
    sif.hold = 1'b0;
    wait_pulse(5, n);
    chk("t3_release", n, 1);

    // timeout forces the step even under hold; err_clr, then set-wins
    do_reset();
    sif.unit_mask = 4'b0100;
    sif.timeout_limit = 8'd5;
    sif.hold = 1'b1;
    wait_pulse(20, n);
    chk("t4_to_lat", n, 7);
    chk("t4_terr", 32'(sif.timeout_err), 1);
    chk("t4_dp", 32'(sif.done_pending), 0);
    sif.hold = 1'b0;
    tick();
    chk("t4_ns_single", 32'(sif.next_state), 0);
    chk("t4_step", 32'(sif.step_cnt), 1);
    chk("t4_state", 32'(st), 1);
    sif.err_clr = 1'b1;
    tick();
    chk("t4_clr", 32'(sif.timeout_err), 0);
    wait_pulse(20, n);
    chk("t4_to_lat2", n, 7);
    chk("t4_set_wins", 32'(sif.timeout_err), 1);
    tick();
    chk("t4_clr2", 32'(sif.timeout_err), 0);
    sif.err_clr = 1'b0;

    // limit 0 disables the timeout
    do_reset();
    sif.unit_mask = 4'b0100;
    wait_pulse(300, n);
    chk("t4_disabled", n, 0);
    chk("t4_dis_terr", 32'(sif.timeout_err), 0);

    // frozen state bus: sync_err after 3 WAIT_CHG cycles, WAIT_CHG done ignored
    do_reset();
    cnt_rst = 1'b1;
    wait_pulse(10, n);
    chk("t5_lat", n, 2);
    sif.unit_mask = 4'b0011;
    sif.unit_done = 4'b0011;
    tick();
    chk("t5_ns_off", 32'(sif.next_state), 0);
    chk("t5_dp_wait", 32'(sif.done_pending), 0);
    tick();
    tick();
    chk("t5_serr_early", 32'(sif.sync_err), 0);
    tick();
    chk("t5_serr", 32'(sif.sync_err), 1);
    sif.unit_done = 4'b0000;
    tick();
    chk("t5_rearm_dp", 32'(sif.done_pending), 4'b0011);

    // reset during PULSE aborts it
    sif.unit_done = 4'b0011;
    sif.unit_mask = 4'b0000;
    wait_pulse(10, n);
    chk("t6_lat", n, 2);
    rst = 1'b1;
    tick();
    chk("t6_ns", 32'(sif.next_state), 0);
    chk("t6_dp", 32'(sif.done_pending), 0);
    chk("t6_terr", 32'(sif.timeout_err), 0);
    chk("t6_serr", 32'(sif.sync_err), 0);
    chk("t6_step", 32'(sif.step_cnt), 0);
    rst = 1'b0;
    sif.unit_mask = 4'b0011;
    sif.unit_done = 4'b0000;
    tick();
    chk("t6_arm_dp", 32'(sif.done_pending), 4'b0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
